// File: rtl/sys_defs.sv
// Shared types and constants for the MCU scheduler.
// The block counts assume 4:2:0 sampling with 16x16 MCUs.
package sys_defs;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } COMP_ID;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } SCHED_STATE;

  localparam int BLKS_PER_MCU     = 6;
  localparam int OUT_BLKS_PER_MCU = 4;

  // Decode order inside an MCU: Y0..Y3, then Cb, then Cr.
  function automatic COMP_ID comp_of_blk(input logic [2:0] blk);
    case (blk)
      3'd4:    return COMP_CB;
      3'd5:    return COMP_CR;
      default: return COMP_Y;
    endcase
  endfunction

endpackage

// File: rtl/mcu_scheduler_if.sv
// Control/status bundle between the JPEG top level and the MCU scheduler.
// master = top level / stimulus side, slave = scheduler.
interface mcu_scheduler_if #(
  parameter int DIM_W = 12
);
  logic             start;
  logic [DIM_W-1:0] mcus_wide;
  logic [DIM_W-1:0] mcus_tall;
  logic             huff_blk_done;
  logic             color_valid;
  logic [1:0]       comp_id;
  logic [2:0]       blk_in_mcu;
  logic             dc_pred_clr;
  logic             decode_hold;
  logic [DIM_W:0]   out_bx;
  logic [DIM_W:0]   out_by;
  logic             busy;
  logic             img_done;
  logic             err;

  modport master (
    output start, mcus_wide, mcus_tall, huff_blk_done, color_valid,
    input  comp_id, blk_in_mcu, dc_pred_clr, decode_hold,
    input  out_bx, out_by, busy, img_done, err
  );

  modport slave (
    input  start, mcus_wide, mcus_tall, huff_blk_done, color_valid,
    output comp_id, blk_in_mcu, dc_pred_clr, decode_hold,
    output out_bx, out_by, busy, img_done, err
  );
endinterface

// File: rtl/mcu_raster_counter.sv
// Raster-order MCU position counter: x wraps at cols-1, then y increments.
// last is high while the position is the bottom-right MCU.
module mcu_raster_counter #(
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIM_W-1:0] cols,
  input  logic [DIM_W-1:0] rows,
  output logic [DIM_W-1:0] x,
  output logic [DIM_W-1:0] y,
  output logic             last
);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [DIM_W-1:0] x_q;
  logic [DIM_W-1:0] y_q;
  logic             x_last;
  logic             y_last;

  assign x_last = (x_q == cols - ONE);
  assign y_last = (y_q == rows - ONE);
  assign last   = x_last & y_last;
  assign x      = x_q;
  assign y      = y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr) begin
      x_q <= '0;
      y_q <= '0;
    end else if (adv) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_q + ONE;
      end else begin
        x_q <= x_q + ONE;
      end
    end
  end

endmodule

// File: rtl/mcu_scheduler.sv
// 4:2:0 MCU sequencer: selects component/table per decoded block, tracks the
// image position of emitted RGB blocks and keeps decode at most MAX_AHEAD MCUs ahead.
module mcu_scheduler
  import sys_defs::*;
#(
  parameter int DIM_W     = 12,
  parameter int MAX_AHEAD = 2
) (
  input logic            clk,
  input logic            rst,
  mcu_scheduler_if.slave bus
);
  localparam int               AW        = $clog2(MAX_AHEAD + 1);
  localparam logic [AW-1:0]    AHEAD_MAX = AW'(MAX_AHEAD);
  localparam logic [AW-1:0]    AHEAD_ONE = AW'(1);
  localparam logic [2:0]       LAST_BLK  = 3'(BLKS_PER_MCU - 1);
  localparam logic [1:0]       LAST_SUB  = 2'(OUT_BLKS_PER_MCU - 1);

  SCHED_STATE       state_q;
  logic [DIM_W-1:0] cols_q;
  logic [DIM_W-1:0] rows_q;
  logic [2:0]       blk_q;
  logic [1:0]       sub_q;
  logic [AW-1:0]    ahead_q;
  logic             dc_clr_q;
  logic             done_q;
  logic             err_q;

  logic             start_acc;
  logic             hold;
  logic             huff_acc;
  logic             color_acc;
  logic             dec_mcu_done;
  logic             out_mcu_done;
  logic             dec_last;
  logic             out_last;
  logic             proto_err;
  logic [DIM_W-1:0] dec_x;
  logic [DIM_W-1:0] dec_y;
  logic [DIM_W-1:0] out_x;
  logic [DIM_W-1:0] out_y;
  logic             unused_dec_pos;

  assign start_acc = bus.start && (state_q == S_IDLE) && (|bus.mcus_wide) && (|bus.mcus_tall);
  assign hold      = (ahead_q >= AHEAD_MAX) || (state_q != S_RUN);
  assign huff_acc  = bus.huff_blk_done && !hold;
  assign color_acc = bus.color_valid && (state_q != S_IDLE) && (ahead_q != '0);

  assign dec_mcu_done = huff_acc && (blk_q == LAST_BLK);
  assign out_mcu_done = color_acc && (sub_q == LAST_SUB);

  assign proto_err = (bus.start && (state_q != S_IDLE))
                   || (bus.huff_blk_done && !huff_acc)
                   || (bus.color_valid && !color_acc);

  // Decode position only matters through its last flag.
  assign unused_dec_pos = ^{dec_x, dec_y};

  mcu_raster_counter #(.DIM_W(DIM_W)) u_dec_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .adv  (dec_mcu_done),
    .cols (cols_q),
    .rows (rows_q),
    .x    (dec_x),
    .y    (dec_y),
    .last (dec_last)
  );

  mcu_raster_counter #(.DIM_W(DIM_W)) u_out_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .adv  (out_mcu_done),
    .cols (cols_q),
    .rows (rows_q),
    .x    (out_x),
    .y    (out_y),
    .last (out_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cols_q   <= '0;
      rows_q   <= '0;
      blk_q    <= '0;
      sub_q    <= '0;
      ahead_q  <= '0;
      dc_clr_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      dc_clr_q <= start_acc;
      done_q   <= 1'b0;
      if (start_acc) begin
        state_q <= S_RUN;
        cols_q  <= bus.mcus_wide;
        rows_q  <= bus.mcus_tall;
        blk_q   <= '0;
        sub_q   <= '0;
        ahead_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (proto_err) begin
          err_q <= 1'b1;
        end
        if (huff_acc) begin
          blk_q <= dec_mcu_done ? 3'd0 : blk_q + 3'd1;
        end
        if (color_acc) begin
          sub_q <= sub_q + 2'd1;
        end
        // Completing an MCU on both sides in one cycle leaves the backlog unchanged.
        case ({dec_mcu_done, out_mcu_done})
          2'b10:   ahead_q <= ahead_q + AHEAD_ONE;
          2'b01:   ahead_q <= ahead_q - AHEAD_ONE;
          default: ahead_q <= ahead_q;
        endcase
        case (state_q)
          S_RUN: begin
            if (dec_mcu_done && dec_last) begin
              state_q <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (out_mcu_done && out_last) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign bus.comp_id     = comp_of_blk(blk_q);
  assign bus.blk_in_mcu  = blk_q;
  assign bus.dc_pred_clr = dc_clr_q;
  assign bus.decode_hold = hold;
  assign bus.out_bx      = {out_x, sub_q[0]};
  assign bus.out_by      = {out_y, sub_q[1]};
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.img_done    = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mcu_scheduler.sv
// Bench for mcu_scheduler: directed scenarios plus randomized images, checked every
// cycle against a count-based model of decoded/emitted blocks.
module tb_mcu_scheduler;
  localparam int DIM_W     = 12;
  localparam int MAX_AHEAD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcu_scheduler_if #(.DIM_W(DIM_W)) bus ();

  mcu_scheduler #(.DIM_W(DIM_W), .MAX_AHEAD(MAX_AHEAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the image is described only by how many blocks have been decoded and emitted.
  bit m_busy = 0, m_err = 0, m_dc = 0, m_done = 0;
  int m_w = 0, m_t = 0, m_ndec = 0, m_nout = 0;

  function automatic int m_ahead();
    return m_ndec / 6 - m_nout / 4;
  endfunction

  function automatic bit m_hold();
    return !m_busy || (m_ndec == 6 * m_w * m_t) || (m_ahead() >= MAX_AHEAD);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_dc = 0; m_done = 0;
    m_w = 0; m_t = 0; m_ndec = 0; m_nout = 0;
  endtask

  task automatic model_step(input bit st, input bit hd, input bit cv, input int w, input int t);
    bit acc_st, acc_h, acc_c;
    acc_st = !m_busy && st && (w != 0) && (t != 0);
    acc_h  = hd && !m_hold();
    acc_c  = cv && m_busy && (m_ahead() > 0);
    m_dc   = acc_st;
    m_done = 0;
    if (acc_st) begin
      m_busy = 1; m_w = w; m_t = t; m_ndec = 0; m_nout = 0; m_err = 0;
    end else begin
      if ((st && m_busy) || (hd && !acc_h) || (cv && !acc_c)) m_err = 1;
      if (acc_h) m_ndec++;
      if (acc_c) begin
        m_nout++;
        if (m_nout == 4 * m_w * m_t) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step(bus.start, bus.huff_blk_done, bus.color_valid,
                    int'(bus.mcus_wide), int'(bus.mcus_tall));
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin : cmp
      int b, m, s;
      b = m_ndec % 6;
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("decode_hold", int'(bus.decode_hold), int'(m_hold()));
      chk("blk_in_mcu", int'(bus.blk_in_mcu), b);
      chk("comp_id", int'(bus.comp_id), (b < 4) ? 0 : b - 3);
      chk("dc_pred_clr", int'(bus.dc_pred_clr), int'(m_dc));
      chk("img_done", int'(bus.img_done), int'(m_done));
      chk("err", int'(bus.err), int'(m_err));
      if (m_busy) begin
        m = m_nout / 4;
        s = m_nout % 4;
        chk("out_bx", int'(bus.out_bx), 2 * (m % m_w) + s % 2);
        chk("out_by", int'(bus.out_by), 2 * (m / m_w) + s / 2);
      end
    end
  end

  task automatic step(input bit st, input bit hd, input bit cv);
    bus.start = st; bus.huff_blk_done = hd; bus.color_valid = cv;
    @(negedge clk);
    bus.start = 0; bus.huff_blk_done = 0; bus.color_valid = 0;
  endtask

  task automatic start_img(input int w, input int t);
    bus.mcus_wide = DIM_W'(w);
    bus.mcus_tall = DIM_W'(t);
    step(1, 0, 0);
  endtask

  // Drive decode/output until img_done; rnd adds gaps, illegal pulses and dim changes.
  task automatic finish_image(input bit rnd, input string tag);
    bit done_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      bit hl, cl, st, hd, cv;
      hl = m_busy && !m_hold();
      cl = m_busy && (m_ahead() > 0);
      if (rnd) begin
        st = ($urandom % 50 == 0);
        hd = hl ? bit'($urandom % 2) : ($urandom % 12 == 0);
        cv = cl ? bit'($urandom % 2) : ($urandom % 12 == 0);
        bus.mcus_wide = DIM_W'($urandom_range(0, 4));
      end else begin
        st = 0; hd = hl; cv = cl;
      end
      step(st, hd, cv);
      if (bus.img_done) begin
        done_seen = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, int'(done_seen), 1);
    chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
  endtask

  initial begin : stim
    int exp_comp [6];
    int exp_bx [4];
    int exp_by [4];
    int ncv, lbx, lby;
    bit fin;
    exp_comp = '{0, 0, 0, 0, 1, 2};
    exp_bx   = '{0, 1, 0, 1};
    exp_by   = '{0, 0, 1, 1};
    bus.start = 0; bus.huff_blk_done = 0; bus.color_valid = 0;
    bus.mcus_wide = '0; bus.mcus_tall = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    cmp_en = 1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_blk", int'(bus.blk_in_mcu), 0);
    chk("rst_bx", int'(bus.out_bx), 0);
    chk("rst_img_done", int'(bus.img_done), 0);

    // 1x1 image
    start_img(1, 1);
    chk("t1_dc_clr", int'(bus.dc_pred_clr), 1);
    chk("t1_busy", int'(bus.busy), 1);
    chk("t1_hold", int'(bus.decode_hold), 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_comp%0d", i), int'(bus.comp_id), exp_comp[i]);
      step(0, 1, 0);
    end
    chk("t1_drain_hold", int'(bus.decode_hold), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_bx%0d", i), int'(bus.out_bx), exp_bx[i]);
      chk($sformatf("t1_by%0d", i), int'(bus.out_by), exp_by[i]);
      step(0, 0, 1);
    end
    chk("t1_img_done", int'(bus.img_done), 1);
    chk("t1_busy_end", int'(bus.busy), 0);
    step(0, 0, 0);
    chk("t1_img_done_pulse", int'(bus.img_done), 0);

    // 3x2 image, backpressure and full output sweep
    start_img(3, 2);
    repeat (12) step(0, 1, 0);
    chk("t2_hold", int'(bus.decode_hold), 1);
    step(0, 1, 0);
    chk("t2_err", int'(bus.err), 1);
    chk("t2_blk", int'(bus.blk_in_mcu), 0);
    repeat (4) step(0, 0, 1);
    chk("t2_hold_release", int'(bus.decode_hold), 0);
    ncv = 4; lbx = -1; lby = -1; fin = 0;
    for (int c = 0; c < 400; c++) begin
      bit hd, cv;
      hd = m_busy && !m_hold();
      cv = m_busy && (m_ahead() > 0);
      if (cv) begin
        lbx = int'(bus.out_bx);
        lby = int'(bus.out_by);
        ncv++;
      end
      step(0, hd, cv);
      if (bus.img_done) begin
        fin = 1;
        break;
      end
    end
    chk("t2_done_seen", int'(fin), 1);
    chk("t2_total_blocks", ncv, 24);
    chk("t2_last_bx", lbx, 5);
    chk("t2_last_by", lby, 3);

    // 3x1 image, decode and output finish an MCU on the same edge
    start_img(3, 1);
    chk("t3_err_cleared", int'(bus.err), 0);
    repeat (6) step(0, 1, 0);
    repeat (5) step(0, 1, 0);
    repeat (3) step(0, 0, 1);
    step(0, 1, 1);
    chk("t3_model_ahead", m_ahead(), 1);
    chk("t3_hold", int'(bus.decode_hold), 0);
    repeat (6) step(0, 1, 0);
    chk("t3_hold_full", int'(bus.decode_hold), 1);
    finish_image(0, "t3");

    // asynchronous reset mid-image
    start_img(2, 2);
    repeat (3) step(0, 1, 0);
    #1 rst = 1;
    #1;
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_blk", int'(bus.blk_in_mcu), 0);
    chk("t4_dc", int'(bus.dc_pred_clr), 0);
    chk("t4_img_done", int'(bus.img_done), 0);
    chk("t4_bx", int'(bus.out_bx), 0);
    chk("t4_hold", int'(bus.decode_hold), 1);
    #1 rst = 0;
    @(negedge clk);
    start_img(1, 1);
    chk("t4_dc_clr", int'(bus.dc_pred_clr), 1);
    chk("t4_blk_restart", int'(bus.blk_in_mcu), 0);
    step(0, 0, 0);
    chk("t4_dc_one_cycle", int'(bus.dc_pred_clr), 0);
    finish_image(0, "t4");

    // zero dimension and idle color_valid
    start_img(0, 3);
    chk("t5_busy", int'(bus.busy), 0);
    step(0, 0, 1);
    chk("t5_err", int'(bus.err), 1);
    start_img(2, 1);
    chk("t5_err_clear", int'(bus.err), 0);
    finish_image(0, "t5");

    // randomized images
    for (int k = 0; k < 15; k++) begin
      start_img($urandom_range(1, 4), $urandom_range(1, 3));
      finish_image(1, $sformatf("rnd%0d", k));
    end

    repeat (2) step(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
